nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that reuses one four_bit_adder slice. Each cycle it feeds that slice one 4-bit nibble of each operand plus the registered carry. It captures the slice's sum and cout, then returns cout as the next nibble's cin. It sits directly downstream of four_bit_adder, consuming its outputs, and replaces a wide ripple adder where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB (localparam), WIDTH/4, number of nibble steps per addition.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled on rising clk edges
a  input  WIDTH  operand A; sampled only on the accepting edge
b  input  WIDTH  operand B; sampled only on the accepting edge
cin  input  1  carry-in to nibble 0; sampled only on the accepting edge
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  carry out of the top nibble
ovf  output  1  two's-complement signed overflow of the full-width add
busy  output  1  high while nibbles are being processed
done  output  1  one-cycle pulse when sum/cout/ovf are valid

Behaviour:
- Single clock domain (clk). rst is asynchronous and active-high.
- On reset: state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; internal operand shift registers, carry register and nibble counter cleared.
- Nibble arithmetic: one instance of four_bit_adder, port order (sum, cout, a, b, cin). Its inputs are the low nibble of each operand shift register plus the carry register.
- States:
  - IDLE (busy=0, done=0).
  - RUN (busy=1, done=0).
  - DONE (busy=0, done=1).
- IDLE -> RUN on start=1:
  - latch a, b into operand shift registers;
  - carry register <= cin;
  - counter <= 0;
  - the output sum register is cleared.
- RUN, every edge:
  - write slice sum into sum[4*counter+3 : 4*counter];
  - carry register <= slice cout;
  - shift both operand registers right by 4;
  - counter += 1.
- RUN -> DONE after the edge that processes nibble NIB-1. At that edge:
  - cout <= slice cout;
  - ovf <= a[WIDTH-1] XNOR b[WIDTH-1], AND-ed with (a[WIDTH-1] XOR final sum[WIDTH-1]), using the latched operand MSBs.
- Latency: start accepted at edge k -> nibbles processed at edges k+1..k+NIB -> done=1 during the cycle after edge k+NIB.
- DONE -> IDLE on the next edge if start=0. DONE -> RUN if start=1, which is back-to-back acceptance with the same latching as from IDLE.
- start while in RUN is ignored; a, b and cin changes during RUN have no effect.
- sum, cout and ovf change only during RUN and at the final edge. They hold in IDLE and DONE. Intermediate sum bits are visible during RUN but are valid only when done=1.
- Reset asserted mid-RUN aborts immediately: all outputs return to their reset values and no done pulse is produced.
- Counter width is clog2(NIB), minimum 1 bit. The terminal compare is against NIB-1, with no wrap-around hazard.
- WIDTH=4 is a legal degenerate case: one RUN cycle.

Test Plan:
1. WIDTH=16, start pulse with a=0x1234, b=0x4321, cin=0 -> busy high for 4 cycles; done high on the 5th cycle after the accepting edge; sum=0x5555, cout=0, ovf=0.
2. a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 nibbles; sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
3. Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. Start 0x0F0F+0x00F1, then pulse start with a=0xAAAA during RUN -> the second start is ignored; result is 0x1000; only one done pulse.
5. Assert rst for 1 cycle at the 2nd RUN cycle -> busy, done, sum, cout and ovf all 0 immediately; state IDLE. A following start with 0x0001+0x0002 -> 0x0003.
6. Hold start=1 continuously, with operands 0x1111+0x2222 then 0x8888+0x8888 presented at consecutive accepting edges -> done pulses 5 cycles apart; results 0x3333 (cout=0), then 0x1110 (cout=1, ovf=1).

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per cycle through a single
// four_bit_adder slice, carrying between nibbles in a register.

module four_bit_adder (
  output logic [3:0] sum,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);
  logic [4:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign {cout, sum} = total;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic [3:0]       s_sum;
  logic             s_cout;
  logic             accept;
  logic             last;

  four_bit_adder u_slice (
    .sum  (s_sum),
    .cout (s_cout),
    .a    (opa[3:0]),
    .b    (opb[3:0]),
    .cin  (carry)
  );

  // A new operation is taken only when the datapath is free; start during RUN is dropped.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == LAST);

  // NOTE: every register here, including the result, is cleared by reset so an
  // aborted addition leaves no stale sum, carry or flags behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values; the slice reads opa/opb/carry from the same cycle they shift.
      state <= RUN;
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      sum   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) sum[4*i +: 4] <= s_sum;
          end
          carry <= s_cout;
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          if (last) begin
            // The top slice sum bit is the final result MSB.
            cout  <= s_cout;
            ovf   <= (a_msb ~^ b_msb) & (a_msb ^ s_sum[3]);
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table plus
// hand-written sequences for mid-RUN start, reset abort and back-to-back starts.

module tb_nibble_serial_adder;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one addition, then count cycles until done; returns latency and busy cycles.
  task automatic run_add(input vec_t v, output int lat, output int busy_cycles);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 50) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, pulses, gap, t_first;
    logic [15:0] seen_sum;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sum",  32'(sum),  32'h0);
    check("reset_cout", 32'(cout), 32'h0);
    check("reset_ovf",  32'(ovf),  32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_add(vecs[i], lat, bc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd4);
      check($sformatf("v%0d_sum", i),  32'(sum),  32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      check($sformatf("v%0d_ovf", i),  32'(ovf),  32'(vecs[i].exp_ovf));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      check($sformatf("v%0d_idle_busy", i),  32'(busy), 32'h0);
      check($sformatf("v%0d_sum_hold", i),   32'(sum),  32'(vecs[i].exp_sum));
    end

    // Start during RUN is ignored: exactly one done, result of the first operands.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    seen_sum = '1;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        pulses++;
        seen_sum = sum;
      end
      @(negedge clk);
    end
    check("runstart_pulses", 32'(pulses), 32'd1);
    check("runstart_sum", 32'(seen_sum), 32'h1000);

    // Reset in the 2nd RUN cycle, right after a result with cout=1 and ovf=1.
    run_add(vecs[8], lat, bc);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_sum",  32'(sum),  32'h0);
    check("abort_cout", 32'(cout), 32'h0);
    check("abort_ovf",  32'(ovf),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_add('{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0}, lat, bc);
    check("post_abort_latency", 32'(lat), 32'd5);
    check("post_abort_sum", 32'(sum), 32'h0003);

    // start held high: back-to-back acceptance from DONE.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h8888; b = 16'h8888;
    lat = 1;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'd5);
    check("b2b_first_sum",  32'(sum),  32'h3333);
    check("b2b_first_cout", 32'(cout), 32'h0);
    check("b2b_first_ovf",  32'(ovf),  32'h0);
    t_first = lat;
    @(negedge clk);
    lat++;
    check("b2b_rerun_busy", 32'(busy), 32'h1);
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    gap = lat - t_first;
    check("b2b_gap", 32'(gap), 32'd5);
    check("b2b_second_sum",  32'(sum),  32'h1110);
    check("b2b_second_cout", 32'(cout), 32'h1);
    check("b2b_second_ovf",  32'(ovf),  32'h1);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
